// File: rtl/seg7_capture_if.sv
// Pin-side and decoded-side signals of the 7-segment capture block.
// master = display/stimulus side, slave = capture block.
interface seg7_capture_if;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] bcd;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        upd;

  modport master (output seg, dig_en, input bcd, valid, blank, err, upd);
  modport slave  (input seg, dig_en, output bcd, valid, blank, err, upd);
endinterface

// File: rtl/seg7_capture.sv
// Recovers BCD digits from a 4-digit multiplexed 7-segment display by sniffing its pins.
// Optional macro SEG7_CAPTURE_TIMEOUT_EN adds a per-digit idle timeout that clears stale status.

module seg7_digit #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit,
  input  logic [6:0] pat_in,
  output logic [3:0] bcd,
  output logic       valid,
  output logic       blank,
  output logic       err,
  output logic       chg
);
  typedef enum logic [1:0] {IDLE, COUNT, LOCKED} state_t;

  state_t     state, state_nx;
  logic [6:0] pat, pat_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] bcd_nx;
  logic       valid_nx, blank_nx, err_nx;
  logic       acc;
  logic       tmo;
  logic [6:0] abc;
  logic [3:0] dec_val;
  logic       dec_ok;

  if (STABLE_CNT < 2 || STABLE_CNT > 15 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
    $error("seg7_digit: STABLE_CNT or TIMEOUT out of range");
  end

`ifdef SEG7_CAPTURE_TIMEOUT_EN
  logic [15:0] idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         idle <= '0;
    else if (hit)                       idle <= '0;
    else if (idle == 16'(TIMEOUT - 1))  idle <= '0;
    else                                idle <= idle + 16'd1;
  end

  assign tmo = !hit && (idle == 16'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // Reorder to a..g reading left-to-right so the table reads like the datasheet.
  assign abc = {pat_in[0], pat_in[1], pat_in[2], pat_in[3], pat_in[4], pat_in[5], pat_in[6]};

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (abc)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
      blank <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      pat   <= pat_nx;
      cnt   <= cnt_nx;
      bcd   <= bcd_nx;
      valid <= valid_nx;
      blank <= blank_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pat_nx   = pat;
    cnt_nx   = cnt;
    acc      = 1'b0;
    if (tmo) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (hit) begin
      case (state)
        IDLE: begin
          state_nx = COUNT;
          pat_nx   = pat_in;
          cnt_nx   = 4'd1;
        end
        COUNT: begin
          if (pat_in == pat) begin
            cnt_nx = cnt + 4'd1;
            if (cnt_nx == 4'(STABLE_CNT)) begin
              state_nx = LOCKED;
              acc      = 1'b1;
            end
          end else begin
            pat_nx = pat_in;
            cnt_nx = 4'd1;
          end
        end
        LOCKED: begin
          // Old status stays visible until the new pattern is itself accepted.
          if (pat_in != pat) begin
            state_nx = COUNT;
            pat_nx   = pat_in;
            cnt_nx   = 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bcd_nx   = bcd;
    valid_nx = valid;
    blank_nx = blank;
    err_nx   = err;
    if (tmo) begin
      valid_nx = 1'b0;
      blank_nx = 1'b0;
      err_nx   = 1'b0;
    end else if (acc) begin
      if (dec_ok) begin
        bcd_nx   = dec_val;
        valid_nx = 1'b1;
        blank_nx = 1'b0;
        err_nx   = 1'b0;
      end else if (pat_in == 7'h7F) begin
        valid_nx = 1'b0;
        blank_nx = 1'b1;
        err_nx   = 1'b0;
      end else begin
        valid_nx = 1'b0;
        blank_nx = 1'b0;
        err_nx   = 1'b1;
      end
    end
  end

  assign chg = {bcd_nx, valid_nx, blank_nx, err_nx} != {bcd, valid, blank, err};
endmodule

module seg7_capture #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input logic          clk,
  input logic          rst_n,
  seg7_capture_if.slave bus
);
  localparam int NUM_DIG = 4;

  logic [6:0]               seg_s1, seg_s2;
  logic [NUM_DIG-1:0]       en_s1, en_s2;
  logic                     qual;
  logic [NUM_DIG-1:0]       hit;
  logic [NUM_DIG-1:0][3:0]  bcd_d;
  logic [NUM_DIG-1:0]       valid_d, blank_d, err_d, chg_d;
  logic                     upd_q;

  // Pins idle high, so the synchroniser resets to the inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      en_s1  <= '1;
      en_s2  <= '1;
    end else begin
      seg_s1 <= bus.seg;
      seg_s2 <= seg_s1;
      en_s1  <= bus.dig_en;
      en_s2  <= en_s1;
    end
  end

  assign qual = $onehot(~en_s2);
  assign hit  = qual ? ~en_s2 : '0;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    seg7_digit #(
      .STABLE_CNT (STABLE_CNT),
      .TIMEOUT    (TIMEOUT)
    ) u_dig (
      .clk    (clk),
      .rst_n  (rst_n),
      .hit    (hit[i]),
      .pat_in (seg_s2),
      .bcd    (bcd_d[i]),
      .valid  (valid_d[i]),
      .blank  (blank_d[i]),
      .err    (err_d[i]),
      .chg    (chg_d[i])
    );
  end

  // Registered alongside the status so the strobe lines up with the change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_q <= 1'b0;
    else        upd_q <= |chg_d;
  end

  assign bus.bcd   = bcd_d;
  assign bus.valid = valid_d;
  assign bus.blank = blank_d;
  assign bus.err   = err_d;
  assign bus.upd   = upd_q;
endmodule
